// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file debug arbiter: debug command and arbiter state encodings.
// The optional CLEAR command is enabled by defining REGFILE_CLEAR_EN.
package regfile_ctrl_pkg;

    localparam int NUM_REGS_DEF = 8;
    localparam int DATA_W_DEF   = 16;

    typedef enum logic [1:0] {
        READ  = 2'b00,
        WRITE = 2'b01,
        DUMP  = 2'b10,
        CLEAR = 2'b11
    } dbg_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        SWEEP
    } arb_state_e;

endpackage

// File: rtl/rf_wait_timer.sv
// Saturating wait counter. It bounds how long a pending debug command yields to the CPU.
// hit is high once the count reaches MAX_WAIT.
module rf_wait_timer #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == LIMIT);

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Shares the register file write port and SR1 read port between the CPU and a debug host.
// Define REGFILE_CLEAR_EN to make CLEAR zero every register; otherwise CLEAR is rejected with dbg_err.
module regfile_debug_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int MAX_WAIT = 4,
    localparam int RIDX_W   = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_active,
    input  logic              cpu_ld_reg,
    input  logic [RIDX_W-1:0] cpu_dr,
    input  logic [RIDX_W-1:0] cpu_sr1,
    input  logic [RIDX_W-1:0] cpu_sr2,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    output logic              LD_REG,
    output logic [RIDX_W-1:0] DR,
    output logic [RIDX_W-1:0] SR1,
    output logic [RIDX_W-1:0] SR2,
    output logic [DATA_W-1:0] In,
    input  logic [DATA_W-1:0] rf_sr1_out,
    input  logic              dbg_req,
    input  logic [1:0]        dbg_cmd,
    input  logic [RIDX_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_busy,
    output logic              dbg_rvalid,
    output logic [RIDX_W-1:0] dbg_ridx,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_REGS - 1);

    arb_state_e        state;
    dbg_cmd_e          cmd;
    logic [RIDX_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [RIDX_W-1:0] idx;
    logic              grant;
    logic              timer_hit;
    logic              clear_rejected;

    // The port is taken on the cycle after the grant decision, so owning cycles are ACCESS and SWEEP.
    assign grant = (state == WAIT) && (!cpu_active || timer_hit);

`ifdef REGFILE_CLEAR_EN
    assign clear_rejected = 1'b0;
`else
    assign clear_rejected = (dbg_cmd_e'(dbg_cmd) == CLEAR);
`endif

    rf_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk   (Clk),
        .rst   (Reset),
        .clear (grant),
        .inc   ((state == WAIT) && !grant),
        .hit   (timer_hit)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cmd        <= READ;
            addr       <= '0;
            wdata      <= '0;
            idx        <= '0;
            dbg_busy   <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_ridx   <= '0;
            dbg_rdata  <= '0;
            dbg_ack    <= 1'b0;
            dbg_err    <= 1'b0;
        end else begin
            dbg_rvalid <= 1'b0;
            dbg_ack    <= 1'b0;
            dbg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg_req) begin
                        cmd   <= dbg_cmd_e'(dbg_cmd);
                        addr  <= dbg_addr;
                        wdata <= dbg_wdata;
                        if (clear_rejected) begin
                            dbg_ack <= 1'b1;
                            dbg_err <= 1'b1;
                        end else begin
                            dbg_busy <= 1'b1;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (grant) begin
                        idx   <= '0;
                        state <= (cmd == READ || cmd == WRITE) ? ACCESS : SWEEP;
                    end
                end
                ACCESS: begin
                    if (cmd == READ) begin
                        dbg_rdata  <= rf_sr1_out;
                        dbg_ridx   <= addr;
                        dbg_rvalid <= 1'b1;
                    end
                    dbg_ack  <= 1'b1;
                    dbg_busy <= 1'b0;
                    state    <= IDLE;
                end
                SWEEP: begin
                    if (cmd == DUMP) begin
                        dbg_rdata  <= rf_sr1_out;
                        dbg_ridx   <= idx;
                        dbg_rvalid <= 1'b1;
                    end
                    // The last register index completes the sweep; idx never wraps.
                    if (idx == LAST_IDX) begin
                        dbg_ack  <= 1'b1;
                        dbg_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SR2 always belongs to the CPU; while owning, the CPU write enable is replaced by the debug one.
    always_comb begin
        LD_REG    = cpu_ld_reg;
        DR        = cpu_dr;
        SR1       = cpu_sr1;
        SR2       = cpu_sr2;
        In        = cpu_data;
        cpu_stall = 1'b0;
        if (state == ACCESS) begin
            LD_REG    = (cmd == WRITE);
            DR        = addr;
            SR1       = addr;
            In        = wdata;
            cpu_stall = cpu_active;
        end else if (state == SWEEP) begin
            LD_REG    = (cmd == CLEAR);
            DR        = idx;
            SR1       = idx;
            In        = '0;
            cpu_stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Self-checking bench for regfile_debug_arbiter with a behavioural register file and reference register image.
// Expectations for CLEAR follow whether REGFILE_CLEAR_EN is defined.
module tb_regfile_debug_arbiter;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int RIDX_W   = 3;
    localparam int MAX_WAIT = 4;

    localparam logic [1:0] C_READ  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_DUMP  = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              cpu_active, cpu_ld_reg, cpu_stall, LD_REG;
    logic [RIDX_W-1:0] cpu_dr, cpu_sr1, cpu_sr2, DR, SR1, SR2;
    logic [DATA_W-1:0] cpu_data, In, rf_sr1_out;
    logic              dbg_req;
    logic [1:0]        dbg_cmd;
    logic [RIDX_W-1:0] dbg_addr, dbg_ridx;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              dbg_busy, dbg_rvalid, dbg_ack, dbg_err;

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] refRegs [NUM_REGS];

    int checks = 0;
    int failures = 0;

    int ackCount, ackCycle, lastBeatCycle, stallCycles, busyBeforeStall;
    int ldCycles, busyCycles, sr2Bad;
    bit stallSeen;
    logic              errSeen;
    logic [RIDX_W-1:0] ldDr;
    logic [DATA_W-1:0] ldIn;
    logic [RIDX_W-1:0] beatIdx[$];
    logic [DATA_W-1:0] beatData[$];

    regfile_debug_arbiter #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .cpu_active (cpu_active),
        .cpu_ld_reg (cpu_ld_reg),
        .cpu_dr     (cpu_dr),
        .cpu_sr1    (cpu_sr1),
        .cpu_sr2    (cpu_sr2),
        .cpu_data   (cpu_data),
        .cpu_stall  (cpu_stall),
        .LD_REG     (LD_REG),
        .DR         (DR),
        .SR1        (SR1),
        .SR2        (SR2),
        .In         (In),
        .rf_sr1_out (rf_sr1_out),
        .dbg_req    (dbg_req),
        .dbg_cmd    (dbg_cmd),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_busy   (dbg_busy),
        .dbg_rvalid (dbg_rvalid),
        .dbg_ridx   (dbg_ridx),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .dbg_err    (dbg_err)
    );

    always #5 Clk = ~Clk;

    // Register file stand-in: contents survive the arbiter's reset.
    always @(posedge Clk) begin
        if (LD_REG) rf[DR] <= In;
    end
    assign rf_sr1_out = rf[SR1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // mode 0: CPU idle, 1: CPU always active, 2: random activity; CPU never writes here.
    task automatic driveCpu(input int mode);
        cpu_active = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cpu_ld_reg = 1'b0;
        cpu_dr     = RIDX_W'($urandom);
        cpu_sr1    = RIDX_W'($urandom);
        cpu_sr2    = RIDX_W'($urandom);
        cpu_data   = DATA_W'($urandom);
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [RIDX_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input int mode, input bit reqAgain);
        ackCount = 0; ackCycle = -1; lastBeatCycle = -1; stallCycles = 0; busyBeforeStall = 0;
        ldCycles = 0; busyCycles = 0; sr2Bad = 0; stallSeen = 0; errSeen = 1'bx;
        ldDr = 'x; ldIn = 'x;
        beatIdx.delete();
        beatData.delete();
        @(negedge Clk);
        dbg_req = 1'b1; dbg_cmd = cmd; dbg_addr = addr; dbg_wdata = wdata;
        driveCpu(mode);
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge Clk);
            dbg_req   = reqAgain && (cyc < 2);
            dbg_cmd   = 2'($urandom);
            dbg_addr  = RIDX_W'($urandom);
            dbg_wdata = DATA_W'($urandom);
            driveCpu(mode);
            #1;
            if (dbg_busy) busyCycles++;
            if (cpu_stall) begin
                stallSeen = 1;
                stallCycles++;
                if (SR2 !== cpu_sr2) sr2Bad++;
            end else if (dbg_busy && !stallSeen) begin
                busyBeforeStall++;
            end
            if (LD_REG) begin ldCycles++; ldDr = DR; ldIn = In; end
            if (dbg_rvalid) begin
                beatIdx.push_back(dbg_ridx);
                beatData.push_back(dbg_rdata);
                lastBeatCycle = cyc;
            end
            if (dbg_ack) begin ackCount++; ackCycle = cyc; errSeen = dbg_err; end
            if (ackCycle >= 0 && cyc >= ackCycle + 6) break;
        end
        dbg_req = 1'b0;
    endtask

    task automatic checkPassthrough(input string tag);
        checkOutput(tag, {5'd0, LD_REG, DR, SR1, SR2, In, cpu_stall},
                    {5'd0, cpu_ld_reg, cpu_dr, cpu_sr1, cpu_sr2, cpu_data, 1'b0});
    endtask

    task automatic checkDump(input string tag);
        checkOutput({tag, "_beats"}, beatData.size(), NUM_REGS);
        for (int k = 0; k < NUM_REGS && k < beatData.size(); k++) begin
            checkOutput($sformatf("%s_ridx%0d", tag, k), beatIdx[k], k);
            checkOutput($sformatf("%s_data%0d", tag, k), beatData[k], refRegs[k]);
        end
        checkOutput({tag, "_ack"}, ackCount, 1);
        checkOutput({tag, "_ack_on_last_beat"}, ackCycle, lastBeatCycle);
        checkOutput({tag, "_stalls"}, stallCycles, NUM_REGS);
    endtask

    // Directed sequence with randomized data and CPU activity around it.
    initial begin
        logic [1:0]        rc;
        logic [RIDX_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        bit                hitBeat3;
        int                lateEvents;

        dbg_req = 1'b0; dbg_cmd = '0; dbg_addr = '0; dbg_wdata = '0;
        driveCpu(0);
        repeat (2) @(negedge Clk);
        #1;
        checkOutput("reset_state", {dbg_busy, dbg_rvalid, dbg_ridx, dbg_rdata, dbg_ack, dbg_err, cpu_stall}, '0);
        Reset = 1'b0;

        for (int k = 0; k < NUM_REGS; k++) begin
            @(negedge Clk);
            driveCpu(1);
            cpu_ld_reg = 1'b1;
            cpu_dr     = RIDX_W'(k);
            refRegs[k] = cpu_data;
            #1;
            checkPassthrough($sformatf("preload_pass%0d", k));
        end

        applyStimulus(C_WRITE, 3'd3, 16'hBEEF, 0, 0);
        refRegs[3] = 16'hBEEF;
        checkOutput("wr3_ld_cycles", ldCycles, 1);
        checkOutput("wr3_dr", ldDr, 3);
        checkOutput("wr3_in", ldIn, 16'hBEEF);
        checkOutput("wr3_ack", ackCount, 1);
        checkOutput("wr3_err", errSeen, 0);
        applyStimulus(C_READ, 3'd3, 16'h0, 0, 0);
        checkOutput("rd3_beats", beatData.size(), 1);
        checkOutput("rd3_data", (beatData.size() > 0) ? beatData[0] : 'x, 16'hBEEF);
        checkOutput("rd3_ack", ackCount, 1);
        checkOutput("rd3_err", errSeen, 0);

        applyStimulus(C_READ, 3'd5, 16'h0, 1, 0);
        checkOutput("starve_stall_cycles", stallCycles, 1);
        checkOutput("starve_wait_cycles", busyBeforeStall, MAX_WAIT + 1);
        checkOutput("starve_data", (beatData.size() > 0) ? beatData[0] : 'x, refRegs[5]);
        checkOutput("starve_ack", ackCount, 1);

        for (int i = 0; i < 6; i++) begin
            rc = 2'($urandom_range(0, 1));
            ra = RIDX_W'($urandom);
            rd = DATA_W'($urandom);
            applyStimulus(rc, ra, rd, 2, 0);
            checkOutput($sformatf("rand%0d_ack", i), ackCount, 1);
            checkOutput($sformatf("rand%0d_stall_le1", i), stallCycles <= 1, 1);
            if (rc == C_WRITE) begin
                checkOutput($sformatf("rand%0d_wr", i), {ldCycles[3:0], ldDr, ldIn}, {4'd1, ra, rd});
                refRegs[ra] = rd;
            end else begin
                checkOutput($sformatf("rand%0d_rd", i), (beatData.size() > 0) ? beatData[0] : 'x, refRegs[ra]);
            end
        end

        for (int k = 0; k < NUM_REGS; k++) begin
            applyStimulus(C_WRITE, RIDX_W'(k), DATA_W'(16'h1000 + k), 0, 0);
            refRegs[k] = DATA_W'(16'h1000 + k);
            checkOutput($sformatf("pre_dump_wr%0d_ack", k), ackCount, 1);
        end
        applyStimulus(C_DUMP, 3'd0, 16'h0, 2, 0);
        checkDump("dump");
        checkOutput("dump_sr2_follow", sr2Bad, 0);

        applyStimulus(C_READ, 3'd6, 16'h0, 0, 1);
        checkOutput("rereq_single_ack", ackCount, 1);
        checkOutput("rereq_data", (beatData.size() > 0) ? beatData[0] : 'x, refRegs[6]);
        checkOutput("rereq_idle_after", dbg_busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            driveCpu(2);
            cpu_ld_reg = 1'($urandom_range(0, 1));
            if (cpu_ld_reg) refRegs[cpu_dr] = cpu_data;
            #1;
            checkPassthrough($sformatf("idle_pass%0d", i));
        end
        @(negedge Clk);
        driveCpu(0);

        applyStimulus(C_CLEAR, 3'd0, 16'h0, 0, 0);
        checkOutput("clear_ack", ackCount, 1);
`ifdef REGFILE_CLEAR_EN
        checkOutput("clear_err", errSeen, 0);
        checkOutput("clear_ld_cycles", ldCycles, NUM_REGS);
        for (int k = 0; k < NUM_REGS; k++) refRegs[k] = '0;
`else
        checkOutput("clear_err", errSeen, 1);
        checkOutput("clear_ack_cycle", ackCycle, 0);
        checkOutput("clear_no_busy", busyCycles, 0);
        checkOutput("clear_no_write", ldCycles, 0);
`endif
        applyStimulus(C_DUMP, 3'd0, 16'h0, 0, 0);
        checkDump("post_clear");

        hitBeat3 = 0;
        @(negedge Clk);
        dbg_req = 1'b1; dbg_cmd = C_DUMP;
        driveCpu(0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clk);
            dbg_req = 1'b0;
            #1;
            if (dbg_rvalid && dbg_ridx == 3'd3) begin hitBeat3 = 1; break; end
        end
        checkOutput("reset_reached_beat3", hitBeat3, 1);
        Reset = 1'b1;
        #1;
        checkOutput("reset_mid_dump", {dbg_busy, dbg_rvalid, dbg_ridx, dbg_rdata, dbg_ack, dbg_err, cpu_stall}, '0);
        @(negedge Clk);
        Reset = 1'b0;
        lateEvents = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            #1;
            if (dbg_ack || dbg_rvalid || dbg_busy) lateEvents++;
        end
        checkOutput("reset_no_ack", lateEvents, 0);
        applyStimulus(C_READ, 3'd2, 16'h0, 0, 0);
        checkOutput("post_reset_rd_ack", ackCount, 1);
        checkOutput("post_reset_rd_data", (beatData.size() > 0) ? beatData[0] : 'x, refRegs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
